// File: rtl/datapath_pkg.sv
// Shared types for the parametrised keypad/register-file/ALU datapath.
// DATAPATH_MUL_EN adds the MUL/WB states used by the shift-add multiplier.
package datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_PASS = 4'd10,
        OP_MUL  = 4'd11
    } op_e;

`ifdef DATAPATH_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC} state_e;
`endif

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic logic [3:0] make_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/datapath_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero.
module datapath_regfile #(
    parameter int  DATA_W = 8,
    parameter int  NREGS  = 16,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

    // NOTE: every comb output gets a default first, so no latch can be inferred.
    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[waddr_i] = wdata_i;
        regs_d[0] = '0;
    end

    // NOTE: the array is reset because the datapath promises all-zero registers
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/datapath_param.sv
// Keypad-loaded register file plus ALU under a start/busy/done handshake.
// Define DATAPATH_MUL_EN to build the multi-cycle shift-add multiplier (op 11).
module datapath_param
    import datapath_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NREGS  = 16,
    parameter int  KEY_W  = 4,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              we_i,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [AW-1:0]     addr_rs1,
    input  logic [AW-1:0]     addr_rs2,
    input  logic [AW-1:0]     addr_rd,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        flags_o,
    output logic [DATA_W-1:0] disp_o
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] disp_q, disp_d;

`ifdef DATAPATH_MUL_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
`endif

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata, rf_rd1, rf_rd2;

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_legal;
    logic [SH_W-1:0]   shamt;

    datapath_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (addr_rs1),
        .raddr2_i (addr_rs2),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    // Bit DATA_W of the widened difference is the unsigned borrow.
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign shamt = b_q[SH_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[DATA_W];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLL:  alu_res = a_q << shamt;
            OP_SRL:  alu_res = a_q >> shamt;
            OP_SRA:  alu_res = $signed(a_q) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, a_q < b_q};
            OP_PASS: alu_res = a_q;
            default: alu_legal = 1'b0;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef DATAPATH_MUL_EN
                    state_d = (op_i == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: state_d = S_IDLE;
`ifdef DATAPATH_MUL_EN
            S_MUL:  if (cnt_q == SH_W'(DATA_W - 1)) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath control; keypad and ALU share the single write port.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = addr_rd;
        rf_wdata = DATA_W'(key_i);
        done_d   = 1'b0;
        flags_d  = flags_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        disp_d   = rf_rd2;
`ifdef DATAPATH_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                rf_we = we_i;
                if (start_i) begin
                    op_d = op_i;
                    rd_d = addr_rd;
                    a_d  = rf_rd1;
                    b_d  = rf_rd2;
`ifdef DATAPATH_MUL_EN
                    acc_d = '0;
                    cnt_d = '0;
`endif
                end
            end
            S_EXEC: begin
                done_d = 1'b1;
                if (alu_legal) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = alu_res;
                    flags_d  = make_flags(alu_v, alu_c, alu_res[MSB], alu_res == '0);
                end
            end
`ifdef DATAPATH_MUL_EN
            // a_q is the shifting multiplicand, b_q the shifting multiplier.
            S_MUL: begin
                if (b_q[0]) acc_d = acc_q + a_q;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + SH_W'(1);
            end
            S_WB: begin
                done_d   = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = acc_q;
                flags_d  = make_flags(1'b0, 1'b0, acc_q[MSB], acc_q == '0);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            disp_q  <= '0;
`ifdef DATAPATH_MUL_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
`ifdef DATAPATH_MUL_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign flags_o = flags_q;
    assign disp_o  = disp_q;

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param: stimulus queues expected result/flags,
// a monitor pops and compares on every done_o pulse.
module tb_datapath_param;
    import datapath_pkg::*;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int KEY_W  = 4;
    localparam int AW     = 4;

`ifdef DATAPATH_MUL_EN
    localparam logic [3:0] ABORT_OP   = 4'd11;
    localparam int         ABORT_EDGE = 4;
`else
    localparam logic [3:0] ABORT_OP   = 4'd0;
    localparam int         ABORT_EDGE = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [KEY_W-1:0]  key_i;
    logic              we_i;
    logic              start_i;
    logic [3:0]        op_i;
    logic [AW-1:0]     addr_rs1, addr_rs2, addr_rd;
    logic              busy_o, done_o;
    logic [3:0]        flags_o;
    logic [DATA_W-1:0] disp_o;

    typedef struct {
        logic [7:0] val;
        logic [3:0] flags;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    datapath_param #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .KEY_W  (KEY_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_i    (key_i),
        .we_i     (we_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .addr_rs1 (addr_rs1),
        .addr_rs2 (addr_rs2),
        .addr_rd  (addr_rd),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .flags_o  (flags_o),
        .disp_o   (disp_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: flags at the done cycle, done width and written value one edge later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("flags", 32'(flags_o), 32'(e.flags));
                    @(negedge clk);
                    check("done_width", 32'(done_o), 32'd0);
                    check("result", 32'(disp_o), 32'(e.val));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic write_key(input logic [3:0] addr, input logic [3:0] key);
        we_i    = 1'b1;
        addr_rd = addr;
        key_i   = key;
        @(posedge clk);
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic check_disp(input logic [3:0] addr, input logic [7:0] exp);
        addr_rs2 = addr;
        @(posedge clk);
        @(negedge clk);
        check("disp_read", 32'(disp_o), 32'(exp));
    endtask

    // Called away from the rising edge; start is sampled on the next edge (t0).
    task automatic run_op(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input int lat, input logic [7:0] exp_val,
                          input logic [3:0] exp_flags, input bit chain, input bit poke);
        int   n;
        exp_t e;
        addr_rs1 = rs1;
        addr_rs2 = rs2;
        addr_rd  = rd;
        op_i     = op;
        start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i  = 1'b0;
        addr_rs2 = rd;
        e.val    = exp_val;
        e.flags  = exp_flags;
        sb.push_back(e);
        check("busy_after_t0", 32'(busy_o), 32'd1);
        n = 1;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
            if (poke && n == 3) begin
                start_i = 1'b1;
                op_i    = OP_ADD;
                we_i    = 1'b1;
                addr_rd = 4'd2;
                key_i   = 4'h9;
            end
            if (poke && n == 4) begin
                start_i = 1'b0;
                we_i    = 1'b0;
            end
        end
        check("done_latency", 32'(n), 32'(lat + 1));
        check("busy_at_done", 32'(busy_o), 32'd0);
        if (!chain) @(negedge clk);
    endtask

    initial begin
        int cnt;
        reset    = 1'b1;
        key_i    = '0;
        we_i     = 1'b0;
        start_i  = 1'b0;
        op_i     = '0;
        addr_rs1 = '0;
        addr_rs2 = '0;
        addr_rd  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_flags", 32'(flags_o), 32'd0);
        check("reset_disp", 32'(disp_o), 32'd0);

        // Keypad loads and r0 write discard
        write_key(4'd1, 4'h2);
        write_key(4'd2, 4'h3);
        write_key(4'd0, 4'h5);
        check_disp(4'd1, 8'h02);
        check_disp(4'd2, 8'h03);
        check_disp(4'd0, 8'h00);

        //      op       rs1    rs2    rd     lat val    {VCNZ}
        run_op(OP_ADD,  4'd1,  4'd2,  4'd3,  1, 8'h05, 4'b0000, 1'b0, 1'b0);
        run_op(OP_SUB,  4'd1,  4'd2,  4'd4,  1, 8'hFF, 4'b0110, 1'b0, 1'b0);
        write_key(4'd5, 4'hF);
        write_key(4'd7, 4'h4);
        write_key(4'd9, 4'h1);
        run_op(OP_SLL,  4'd5,  4'd7,  4'd6,  1, 8'hF0, 4'b0010, 1'b0, 1'b0);
        run_op(OP_SRL,  4'd4,  4'd9,  4'd8,  1, 8'h7F, 4'b0000, 1'b0, 1'b0);
        run_op(OP_ADD,  4'd8,  4'd9,  4'd10, 1, 8'h80, 4'b1010, 1'b0, 1'b0);
        run_op(OP_ADD,  4'd4,  4'd9,  4'd11, 1, 8'h00, 4'b0101, 1'b0, 1'b0);
        run_op(OP_SRA,  4'd6,  4'd7,  4'd11, 1, 8'hFF, 4'b0010, 1'b0, 1'b0);
        run_op(OP_SLT,  4'd4,  4'd1,  4'd12, 1, 8'h01, 4'b0000, 1'b0, 1'b0);
        run_op(OP_SLTU, 4'd4,  4'd1,  4'd12, 1, 8'h00, 4'b0001, 1'b0, 1'b0);
        run_op(OP_XOR,  4'd1,  4'd2,  4'd13, 1, 8'h01, 4'b0000, 1'b0, 1'b0);
        run_op(OP_AND,  4'd5,  4'd6,  4'd13, 1, 8'h00, 4'b0001, 1'b0, 1'b0);
        run_op(OP_OR,   4'd5,  4'd6,  4'd13, 1, 8'hFF, 4'b0010, 1'b0, 1'b0);
        run_op(OP_PASS, 4'd6,  4'd0,  4'd14, 1, 8'hF0, 4'b0010, 1'b0, 1'b0);
        // Illegal opcode: r3 keeps 0x05, flags keep the PASS result
        run_op(4'd13,   4'd1,  4'd2,  4'd3,  1, 8'h05, 4'b0010, 1'b0, 1'b0);

`ifdef DATAPATH_MUL_EN
        run_op(OP_SLL,  4'd9,  4'd7,  4'd13, 1, 8'h10, 4'b0000, 1'b0, 1'b0);
        run_op(OP_ADD,  4'd13, 4'd9,  4'd13, 1, 8'h11, 4'b0000, 1'b0, 1'b0);
        // 0x0F x 0x11 with a start and a keypad write poked in at t3
        run_op(OP_MUL,  4'd5,  4'd13, 4'd14, 9, 8'hFF, 4'b0010, 1'b0, 1'b1);
        check_disp(4'd2, 8'h03);
`else
        run_op(OP_MUL,  4'd5,  4'd1,  4'd14, 1, 8'hF0, 4'b0010, 1'b0, 1'b0);
`endif

        // Reset in the middle of an operation
        addr_rs1 = 4'd5;
        addr_rs2 = 4'd13;
        addr_rd  = 4'd15;
        op_i     = ABORT_OP;
        start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i  = 1'b0;
        addr_rs2 = 4'd15;
        repeat (ABORT_EDGE - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_flags", 32'(flags_o), 32'd0);
        check("abort_disp", 32'(disp_o), 32'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        check_disp(4'd15, 8'h00);
        check_disp(4'd5, 8'h00);

        // Fresh ops after reset, second start taken on the edge ending done_o
        write_key(4'd1, 4'h6);
        write_key(4'd2, 4'h7);
        run_op(OP_ADD,  4'd1,  4'd2,  4'd3,  1, 8'h0D, 4'b0000, 1'b1, 1'b0);
        run_op(OP_ADD,  4'd1,  4'd3,  4'd4,  1, 8'h13, 4'b0000, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
